// File: rtl/tx_frame_ctrl.sv
// Transmit sequencer for the flex_pts_sr shift register. It frames a word as start(0), data LSB-first, stop(1),
// and drives load/shift strobes so that each bit is held for CLKS_PER_BIT cycles.
module tx_frame_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic                 abort,
    output logic                 load_enable,
    output logic                 shift_enable,
    output logic [DATA_BITS+1:0] frame_out,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int FRAME_BITS = DATA_BITS + 2;
    localparam int CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW         = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BIT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;
    logic          bit_end;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state   = state;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        busy         = 1'b1;
        tx_done      = 1'b0;
        tx_ready     = 1'b0;
        bit_end      = (clk_cnt == CLK_LAST);
        case (state)
            S_IDLE: begin
                busy     = 1'b0;
                tx_ready = !rst;
                if (tx_valid && !rst) next_state = S_LOAD;
            end
            S_LOAD: begin
                load_enable = 1'b1;
                next_state  = abort ? S_ABORT : S_BIT;
            end
            S_BIT: begin
                shift_enable = bit_end;
                if (abort)                             next_state = S_ABORT;
                else if (bit_end && bit_cnt == BIT_LAST) next_state = S_DONE;
            end
            S_DONE: begin
                tx_done    = 1'b1;
                next_state = S_IDLE;
            end
            S_ABORT: begin
                load_enable = 1'b1;
                next_state  = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_out <= '1;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (tx_valid) frame_out <= {1'b1, tx_data, 1'b0};
                S_LOAD: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                end
                S_BIT: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // Entering IDLE or ABORT forces the frame to all ones so that any reload drives the line high.
            if (next_state == S_IDLE || next_state == S_ABORT) frame_out <= '1;
        end
    end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Scoreboard bench for tx_frame_ctrl with a behavioural flex_pts_sr model (LSB out, fills with 1s),
// covering two bit rates: CLKS_PER_BIT=4 (index 0) and CLKS_PER_BIT=1 (index 1).
module tb_tx_frame_ctrl;

    localparam int F = 10;

    typedef struct {
        int cyc;
        bit ser;
        bit sh;
        bit ld;
        bit bsy;
        bit dn;
        bit rdy;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      v, ab, rdy, ld, sh, bsy, dn, ser;
    logic [1:0][7:0] d;
    logic [1:0][9:0] fo;
    logic [9:0]      sr0, sr1;
    int              n_tests = 0;
    int              n_fail  = 0;
    exp_t            sb[$];

    always #5 clk = ~clk;

    tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .tx_valid(v[0]), .tx_data(d[0]), .tx_ready(rdy[0]), .abort(ab[0]),
        .load_enable(ld[0]), .shift_enable(sh[0]), .frame_out(fo[0]), .busy(bsy[0]), .tx_done(dn[0])
    );

    tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_valid(v[1]), .tx_data(d[1]), .tx_ready(rdy[1]), .abort(ab[1]),
        .load_enable(ld[1]), .shift_enable(sh[1]), .frame_out(fo[1]), .busy(bsy[1]), .tx_done(dn[1])
    );

    always @(posedge clk or posedge rst) begin
        if (rst)        sr0 <= '1;
        else if (ld[0]) sr0 <= fo[0];
        else if (sh[0]) sr0 <= {1'b1, sr0[9:1]};
    end

    always @(posedge clk or posedge rst) begin
        if (rst)        sr1 <= '1;
        else if (ld[1]) sr1 <= fo[1];
        else if (sh[1]) sr1 <= {1'b1, sr1[9:1]};
    end

    assign ser = {sr1[0], sr0[0]};

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the negedge of the handshake cycle (cycle 0); returns at the negedge where tx_ready is back.
    task automatic run_frame(input int i, input logic [7:0] data, input bit hold, input int ab_cyc);
        int         c;
        int         last;
        logic [9:0] fr;
        exp_t       e;
        string      t;
        c    = (i == 0) ? 4 : 1;
        fr   = {1'b1, data, 1'b0};
        last = (ab_cyc > 0) ? ab_cyc + 2 : F * c + 3;
        check($sformatf("d%0d hs_ready", i), rdy[i], 1);
        v[i] = 1'b1;
        d[i] = data;
        for (int k = 1; k <= last; k++) begin
            e.cyc = k;
            e.ld  = (k == 1) || (ab_cyc > 0 && k == ab_cyc + 1);
            e.sh  = (k >= 2 && k <= F * c + 1 && ((k - 2) % c) == c - 1 && (ab_cyc <= 0 || k <= ab_cyc));
            e.ser = (k >= 2 && k <= F * c + 1) ? fr[(k - 2) / c] : 1'b1;
            if (ab_cyc > 0 && k >= ab_cyc + 2) e.ser = 1'b1;
            e.dn  = (ab_cyc <= 0 && k == F * c + 2);
            e.rdy = (k == last);
            e.bsy = (k != last);
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            t = $sformatf("d%0d c%0d", i, e.cyc);
            check({t, " serial"}, ser[i], e.ser);
            check({t, " shift"}, sh[i], e.sh);
            check({t, " load"}, ld[i], e.ld);
            check({t, " busy"}, bsy[i], e.bsy);
            check({t, " done"}, dn[i], e.dn);
            check({t, " ready"}, rdy[i], e.rdy);
            if (e.cyc == 1)                   check({t, " frame"}, fo[i], fr);
            else if (e.ld || e.cyc == last)   check({t, " frame"}, fo[i], 10'h3FF);
            ab[i] = (e.cyc == ab_cyc);
            if (hold) begin
                v[i] = 1'b1;
                d[i] = 8'($urandom);
            end else begin
                v[i] = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        v   = '0;
        ab  = '0;
        d   = '0;
        @(negedge clk);
        check("rst ready_low", rdy[0], 0);
        @(negedge clk);
        check("rst busy", bsy[0], 0);
        check("rst load", ld[0], 0);
        check("rst shift", sh[0], 0);
        check("rst done", dn[0], 0);
        check("rst frame", fo[0], 10'h3FF);
        check("rst serial", ser[0], 1);
        check("rst ready_held", rdy[0], 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst ready_after", rdy[0], 1);
        check("rst ready_after1", rdy[1], 1);

        run_frame(0, 8'hA5, 1'b0, 0);
        // Valid held high with changing data; the next word is offered in the first IDLE cycle.
        run_frame(0, 8'h5A, 1'b1, 0);
        run_frame(0, 8'h3C, 1'b0, 0);
        run_frame(0, 8'hC3, 1'b0, 15);
        run_frame(0, 8'h96, 1'b0, 41);
        run_frame(0, 8'h0F, 1'b0, 1);

        v[0] = 1'b1;
        d[0] = 8'h81;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            v[0] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", bsy[0], 0);
        check("midrst load", ld[0], 0);
        check("midrst shift", sh[0], 0);
        check("midrst done", dn[0], 0);
        check("midrst frame", fo[0], 10'h3FF);
        check("midrst serial", ser[0], 1);
        check("midrst ready_low", rdy[0], 0);
        @(negedge clk);
        check("midrst ready_held", rdy[0], 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst ready_after", rdy[0], 1);
        for (int k = 0; k < 45; k++) begin
            check($sformatf("midrst c%0d no_done", k), dn[0], 0);
            check($sformatf("midrst c%0d line", k), ser[0], 1);
            @(negedge clk);
        end

        run_frame(1, 8'h00, 1'b0, 0);
        run_frame(1, 8'h00, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
